// File: rtl/motion_pkg.sv
// motion_pkg: command codes, FSM state encodings and helpers shared by the motion sequencer
package motion_pkg;
  typedef logic [2:0] cmd_t;
  typedef logic [2:0] state_t;
  typedef logic [1:0] speed_t;
  typedef struct packed {
    cmd_t   cmd;
    speed_t speed;
  } req_t;
  localparam cmd_t CMD_STOP  = 3'd0;
  localparam cmd_t CMD_FWD   = 3'd1;
  localparam cmd_t CMD_REV   = 3'd2;
  localparam cmd_t CMD_LEFT  = 3'd3;
  localparam cmd_t CMD_RIGHT = 3'd4;
  localparam state_t S_IDLE  = 3'd0;
  localparam state_t S_RAMP  = 3'd1;
  localparam state_t S_RUN   = 3'd2;
  localparam state_t S_SLOW  = 3'd3;
  localparam state_t S_DWELL = 3'd4;
  localparam state_t S_ESTOP = 3'd5;
  function automatic cmd_t norm_cmd(input cmd_t c);
    return (c > CMD_RIGHT) ? CMD_STOP : c;
  endfunction
  function automatic int max3(input int a, input int b, input int c);
    return (a > b) ? ((a > c) ? a : c) : ((b > c) ? b : c);
  endfunction
endpackage

// File: rtl/motion_tick.sv
// motion_tick: loadable down-counter with clear; o_zero flags expiry for ramp and dwell timing
module motion_tick #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_clr,
  input  logic         i_load,
  input  logic [W-1:0] i_value,
  output logic         o_zero
);
  logic [W-1:0] r_cnt;
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) r_cnt <= '0;
    else if (i_load) r_cnt <= i_value;
    else if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
  end
  assign o_zero = (r_cnt == '0);
endmodule

// File: rtl/motion_sequencer.sv
// motion_sequencer: arbitrates manual/auto drive requests, ramps speed and enforces stop-and-dwell.
// Optional autonomous refresh watchdog enabled by defining MOTION_WATCHDOG_EN.
module motion_sequencer
  import motion_pkg::*;
#(
  parameter int RAMP_TICKS  = 5_000_000,
  parameter int DWELL_TICKS = 10_000_000,
  parameter int WDOG_TICKS  = 50_000_000
) (
  input  logic       CLK100MHZ,
  input  logic       reset,
  input  logic       estop,
  input  logic       man_req,
  input  logic [2:0] man_cmd,
  input  logic [1:0] man_speed,
  output logic       man_ack,
  input  logic       auto_req,
  input  logic [2:0] auto_cmd,
  input  logic [1:0] auto_speed,
  output logic       auto_ack,
  output logic [2:0] movementCommand,
  output logic [1:0] curSpeed,
  output logic [1:0] speedChange,
  output logic       busy,
  output logic       wdog_trip
);
  localparam int TW = $clog2(max3(RAMP_TICKS, DWELL_TICKS, WDOG_TICKS)) + 1;
  localparam logic [TW-1:0] RAMP_LD  = TW'(RAMP_TICKS - 1);
  localparam logic [TW-1:0] DWELL_LD = TW'(DWELL_TICKS - 1);
  state_t r_state, w_state;
  cmd_t r_cmd, w_cmd;
  speed_t r_speed, w_speed, r_tgt, w_tgt, w_step;
  req_t r_pend, w_pend, w_req;
  logic [1:0] r_sc, w_sc;
  logic r_man_ack, r_auto_ack, r_busy, r_man_armed, r_auto_armed;
  logic w_man_v, w_auto_v, w_acc, w_man_ack, w_auto_ack, w_go, w_pend_go;
  logic w_load, w_tick, w_trip;
  logic [TW-1:0] w_load_val;
  assign w_man_v    = man_req & r_man_armed;
  assign w_auto_v   = auto_req & r_auto_armed;
  assign w_acc      = !estop && !w_trip && (r_state == S_IDLE || r_state == S_RUN) && (w_man_v || w_auto_v);
  assign w_man_ack  = w_acc & w_man_v;
  assign w_auto_ack = w_acc & !w_man_v;
  assign w_req      = w_man_v ? {norm_cmd(man_cmd), man_speed} : {norm_cmd(auto_cmd), auto_speed};
  assign w_go       = (w_req.cmd != CMD_STOP) && (w_req.speed != 2'd0);
  assign w_pend_go  = (r_pend.cmd != CMD_STOP) && (r_pend.speed != 2'd0);
  assign w_step     = (r_speed < r_tgt) ? r_speed + 2'd1 : r_speed - 2'd1;
  motion_tick #(.W(TW)) u_tick (
    .i_clk  (CLK100MHZ),
    .i_rst  (reset),
    .i_clr  (estop),
    .i_load (w_load),
    .i_value(w_load_val),
    .o_zero (w_tick)
  );
  always_comb begin
    w_state    = r_state;
    w_cmd      = r_cmd;
    w_speed    = r_speed;
    w_tgt      = r_tgt;
    w_pend     = r_pend;
    w_sc       = 2'b00;
    w_load     = 1'b0;
    w_load_val = RAMP_LD;
    if (estop) begin
      w_state = S_ESTOP;
      w_cmd   = CMD_STOP;
      w_speed = 2'd0;
      w_tgt   = 2'd0;
      w_pend  = '0;
      w_sc    = 2'b11;
    end else if (w_trip) begin
      w_state = S_SLOW;
      w_pend  = '0;
      w_load  = 1'b1;
    end else begin
      case (r_state)
        S_IDLE: if (w_acc && w_go) begin
          w_cmd   = w_req.cmd;
          w_tgt   = w_req.speed;
          w_state = S_RAMP;
          w_load  = 1'b1;
        end
        S_RAMP: if (r_speed == r_tgt) w_state = S_RUN;
        else if (w_tick) begin
          w_speed = w_step;
          w_load  = 1'b1;
          w_state = (w_step == r_tgt) ? S_RUN : S_RAMP;
        end
        S_RUN: if (w_acc) begin
          if (w_go && w_req.cmd == r_cmd) begin
            w_tgt   = w_req.speed;
            w_state = (w_req.speed != r_speed) ? S_RAMP : S_RUN;
            w_load  = (w_req.speed != r_speed);
          end else begin
            w_pend  = w_req;
            w_state = S_SLOW;
            w_load  = 1'b1;
          end
        end
        // reaching zero drops the direction in the same edge that enters DWELL
        S_SLOW: if (r_speed == 2'd0 || (w_tick && r_speed == 2'd1)) begin
          w_speed    = 2'd0;
          w_cmd      = CMD_STOP;
          w_state    = S_DWELL;
          w_load     = 1'b1;
          w_load_val = DWELL_LD;
        end else if (w_tick) begin
          w_speed = r_speed - 2'd1;
          w_load  = 1'b1;
        end
        S_DWELL: if (w_tick) begin
          w_pend  = '0;
          w_state = w_pend_go ? S_RAMP : S_IDLE;
          w_cmd   = w_pend_go ? r_pend.cmd : CMD_STOP;
          w_tgt   = w_pend_go ? r_pend.speed : r_tgt;
          w_load  = w_pend_go;
        end
        S_ESTOP: begin
          w_state    = S_DWELL;
          w_pend     = '0;
          w_load     = 1'b1;
          w_load_val = DWELL_LD;
        end
        default: w_state = S_IDLE;
      endcase
    end
  end
  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_cmd        <= CMD_STOP;
      r_speed      <= 2'd0;
      r_tgt        <= 2'd0;
      r_pend       <= '0;
      r_sc         <= 2'b00;
      r_man_ack    <= 1'b0;
      r_auto_ack   <= 1'b0;
      r_busy       <= 1'b0;
      r_man_armed  <= 1'b1;
      r_auto_armed <= 1'b1;
    end else begin
      r_state      <= w_state;
      r_cmd        <= w_cmd;
      r_speed      <= w_speed;
      r_tgt        <= w_tgt;
      r_pend       <= w_pend;
      r_sc         <= w_sc;
      r_man_ack    <= w_man_ack;
      r_auto_ack   <= w_auto_ack;
      r_busy       <= (w_state != S_IDLE);
      r_man_armed  <= !man_req || (r_man_armed && !w_man_ack);
      r_auto_armed <= !auto_req || (r_auto_armed && !w_auto_ack);
    end
  end
`ifdef MOTION_WATCHDOG_EN
  localparam logic [TW-1:0] WDOG_LD = TW'(WDOG_TICKS - 1);
  logic r_last_auto, r_trip, w_wdog_run;
  logic [TW-1:0] r_wdog;
  assign w_wdog_run = r_last_auto && (r_state == S_RAMP || r_state == S_RUN);
  assign w_trip     = w_wdog_run && (r_wdog == WDOG_LD);
  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      r_last_auto <= 1'b0;
      r_wdog      <= '0;
      r_trip      <= 1'b0;
    end else begin
      r_last_auto <= w_man_ack ? 1'b0 : (w_auto_ack ? 1'b1 : r_last_auto);
      r_wdog      <= (w_auto_ack || !w_wdog_run || w_trip) ? '0 : r_wdog + 1'b1;
      r_trip      <= w_trip && !estop;
    end
  end
  assign wdog_trip = r_trip;
`else
  assign w_trip    = 1'b0;
  assign wdog_trip = 1'b0;
`endif
  assign movementCommand = r_cmd;
  assign curSpeed        = r_speed;
  assign speedChange     = r_sc;
  assign man_ack         = r_man_ack;
  assign auto_ack        = r_auto_ack;
  assign busy            = r_busy;
endmodule

// File: doc/motion_sequencer.md
# motion_sequencer

Sequences motor commands into the tank's movement datapath. It arbitrates drive requests from a manual requester and an autonomous requester, ramps speed one level at a time, and enforces a stop-and-dwell before any direction change. It also implements an emergency stop. Outputs drive `movementCommand`, `curSpeed` and `speedChange` of `movementMain` directly.

## Interface
- `RAMP_TICKS`, 5_000_000: cycles between single-level speed steps (50 ms).
- `DWELL_TICKS`, 10_000_000: cycles held at STOP before a new direction is applied.
- `WDOG_TICKS`, 50_000_000: autonomous refresh timeout; used only with `MOTION_WATCHDOG_EN`.
- `CLK100MHZ  in  1`: system clock. One clock domain.
- `reset  in  1`: synchronous, active-high reset.
- `estop  in  1`: level emergency stop.
- `man_req  in  1` / `man_cmd  in  3` / `man_speed  in  2`: manual request and its target.
- `man_ack  out  1`: one-cycle accept pulse for the manual requester.
- `auto_req  in  1` / `auto_cmd  in  3` / `auto_speed  in  2`: autonomous request and its target.
- `auto_ack  out  1`: one-cycle accept pulse for the autonomous requester.
- `movementCommand  out  3`: direction to `movementMain`.
- `curSpeed  out  2`: speed level 0–3.
- `speedChange  out  2`: 2'b00 normal, 2'b11 forced 0 % duty.
- `busy  out  1`: high in any state other than IDLE.
- `wdog_trip  out  1`: one-cycle pulse when the watchdog fires.

## Operation
- Command codes: `CMD_STOP`=0, `CMD_FWD`=1, `CMD_REV`=2, `CMD_LEFT`=3, `CMD_RIGHT`=4. Codes 5–7 are treated as `CMD_STOP`.
- States: IDLE, RAMP, RUN, SLOW, DWELL, ESTOP.
- Reset values: state IDLE, `movementCommand`=0, `curSpeed`=0, `speedChange`=00, both acks 0, `busy`=0, `wdog_trip`=0. All counters 0; target and pending registers cleared.
- **Accept:** requests are accepted only in IDLE and RUN, and only when estop=0.
  - If both requesters are high, manual wins and auto waits.
  - A requester is re-armed only after its req has been sampled low. A req held high after its ack is never accepted twice.
- **IDLE:**
  - On accept with a non-STOP cmd and speed>0: `movementCommand`←cmd, target←speed, go to RAMP.
  - Any other request is acked and the block stays in IDLE.
- **RAMP:**
  - Each ramp tick moves `curSpeed` one level toward target.
  - When `curSpeed` equals target, go to RUN.
- **RUN:**
  - Accept with the same cmd and speed>0: new target, go to RAMP. Ramping up or down is allowed; if the new target equals the current speed, stay in RUN.
  - Accept with a different cmd, STOP, or speed 0: latch the request as pending, go to SLOW.
- **SLOW:**
  - Each ramp tick decrements `curSpeed`.
  - When `curSpeed` reaches 0: `movementCommand`←STOP, go to DWELL.
- **DWELL:**
  - Hold for `DWELL_TICKS` cycles.
  - Then, if pending is non-STOP with speed>0: apply its cmd and go to RAMP. Otherwise go to IDLE.
- **ESTOP:**
  - Entered from any state while estop=1.
  - Outputs: `speedChange`=11, `curSpeed`=0, `movementCommand`=STOP.
  - Target and pending are cleared.
  - On estop=0, go to DWELL with pending=STOP, then IDLE.
- **Reset mid-operation:** returns to reset values on the next edge. No dwell is applied.

## Timing
- **Accept timing:** a req sampled high at edge N in an accept state produces ack high in cycle N+1 for exactly one cycle. The resulting `movementCommand`/state update is visible in the same cycle N+1.
- **Ramp timing:**
  - The ramp counter clears on entry to RAMP or SLOW.
  - The first step occurs `RAMP_TICKS` cycles after entry, then every `RAMP_TICKS` cycles.
  - A 0→3 ramp completes in 3×`RAMP_TICKS` cycles.
- **Dwell timing:** DWELL lasts exactly `DWELL_TICKS` cycles, counted from the entry cycle.
- **Estop timing:**
  - estop sampled at edge N drives the ESTOP outputs in cycle N+1.
  - estop overrides a simultaneous accept: no ack is given.
- `busy` is registered alongside state.

## Configuration
- `MOTION_WATCHDOG_EN` defined:
  - While the last accepted request was autonomous and the state is RAMP or RUN, a counter runs.
  - The counter clears on each `auto_ack`.
  - When it reaches `WDOG_TICKS`: pulse `wdog_trip` and take the SLOW path with pending=STOP.
- Undefined: no watchdog logic; `wdog_trip` is tied 0.

## Structure
- `motion_pkg`: command code constants, state enum, speed level type (2-bit).
- Sub-module `motion_tick`: a loadable down-counter with clear, used for both the ramp tick and the dwell timer.

## Test plan
(RAMP_TICKS=4, DWELL_TICKS=8, WDOG_TICKS=64)
- Reset, then `man_req` FWD/3:
  - `man_ack` 1 cycle later.
  - `curSpeed` 1, 2, 3 at +4, +8, +12 cycles after RAMP entry.
  - RUN reached, `busy`=1.
- In RUN FWD/3, auto REV/2:
  - `curSpeed` steps down to 0, then `movementCommand`=STOP for 8 cycles.
  - Then `movementCommand`=REV and the ramp runs to 2.
- Same-cycle `man_req` and `auto_req` in IDLE:
  - Only `man_ack` fires.
  - `auto_ack` fires after `man_req` drops and the sequencer is back in RUN.
- estop pulsed during RAMP at speed 2:
  - Next cycle `speedChange`=11, `curSpeed`=0, no acks.
  - After release, 8-cycle DWELL, then IDLE.
- `auto_req` held high for 20 cycles: exactly one `auto_ack`.
- Watchdog build: auto FWD/1 with no refresh → `wdog_trip` at cycle 64, then SLOW→DWELL→IDLE. Non-watchdog build: RUN holds indefinitely.
